// File: rtl/pipo_arb_pkg.sv
// Shared types and defaults for the PIPO load arbiter and its round-robin picker.
package pipo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 4;

    // Width of an index into N requesters; never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipo_load_arbiter_if.sv
// Request/grant and parallel-output bundle between requesters, consumer and arbiter.
interface pipo_load_arbiter_if
    import pipo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) ();
    localparam int OW = owner_w(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] req_data;
    logic [N_REQ-1:0]   gnt;
    logic               flush;
    logic [W-1:0]       po;
    logic               po_valid;
    logic [OW-1:0]      po_owner;
    logic               po_ack;

    modport master (
        output req, req_data, flush, po_ack,
        input  gnt, po, po_valid, po_owner
    );

    modport slave (
        input  req, req_data, flush, po_ack,
        output gnt, po, po_valid, po_owner
    );

endinterface

// File: rtl/pipo_load_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int OW   = owner_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [OW-1:0]    idx,
    output logic             any
);

    logic [OW:0]   sum;
    logic [OW-1:0] cand;

    always_comb begin
        sum  = '0;
        cand = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum  = {1'b0, ptr} + (OW+1)'(k);
            cand = (sum >= (OW+1)'(N_REQ)) ? OW'(sum - (OW+1)'(N_REQ)) : sum[OW-1:0];
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        gnt = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Single holding register shared by N requesters; round-robin load, ack to release.
module pipo_load_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input logic                clk,
    input logic                rst_n,
    pipo_load_arbiter_if.slave bus
);

    localparam int OW = owner_w(N_REQ);

    state_t           state_reg, state_next;
    logic [OW-1:0]    ptr_reg, ptr_next;
    logic [OW-1:0]    owner_reg;
    logic [W-1:0]     po_reg;
    logic [N_REQ-1:0] arb_gnt, gnt_comb;
    logic [OW-1:0]    arb_idx;
    logic             arb_any;
    logic             load, clear;
    logic [W-1:0]     data_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data
            assign data_arr[gi] = bus.req_data[gi*W +: W];
        end
    endgenerate

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req (bus.req),
        .ptr (ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign ptr_next = (arb_idx == OW'(N_REQ - 1)) ? '0 : arb_idx + OW'(1);

    always_comb begin
        state_next = state_reg;
        gnt_comb   = '0;
        load       = 1'b0;
        clear      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.flush) begin
                    clear = 1'b1;
                end else if (arb_any) begin
                    gnt_comb   = arb_gnt;
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                // flush takes priority over a simultaneous ack
                if (bus.flush) begin
                    clear      = 1'b1;
                    state_next = IDLE;
                end else if (bus.po_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            po_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (clear) begin
                po_reg    <= '0;
                owner_reg <= '0;
            end else if (load) begin
                po_reg    <= data_arr[arb_idx];
                owner_reg <= arb_idx;
                ptr_reg   <= ptr_next;
            end
        end
    end

    assign bus.gnt      = rst_n ? gnt_comb : '0;
    assign bus.po       = po_reg;
    assign bus.po_valid = (state_reg == FULL);
    assign bus.po_owner = owner_reg;

endmodule
